// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O block: seven-segment glyphs,
// PS/2 frame field positions and the receiver state encoding.
package board_io_pkg;

    localparam int FRAME_BITS = 11;
    localparam int START_POS  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_POS = 9;
    localparam int STOP_POS   = 10;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low glyphs, bit0=a .. bit6=g, bit7=dp (kept off).
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/board_io_if.sv
// Keyboard result bus from the PS/2 receiver to the display logic.
interface board_io_if;
    import board_io_pkg::*;

    // ready is a one-cycle strobe qualifying code; there is no backpressure,
    // so the consumer must take code in the cycle ready is high.
    logic [7:0] code;
    logic       ready;
    logic [7:0] count;
    ps2_state_t state;

    modport master (output code, output ready, output count, output state);
    modport slave  (input code, input ready, input count, input state);

endinterface

// File: rtl/board_io_ps2_rx.sv
// PS/2 receiver: synchronizers, falling-edge detect, 11-bit shift register,
// frame validation one cycle after the stop bit, and an idle-clock timeout.
module ps2_rx
    import board_io_pkg::*;
#(
    parameter int PS2_TIMEOUT = 50_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    board_io_if.master kbd
);

    localparam int TW = $clog2(PS2_TIMEOUT + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic                  clk_hist;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    ps2_state_t            state_q, state_d;
    logic [7:0]            code_q;
    logic                  ready_q;
    logic [7:0]            count_q;
    logic                  fall;
    logic                  frame_ok;
    logic                  accept;

    assign fall     = clk_hist & ~clk_sync[1];
    assign frame_ok = ~frame_q[START_POS] & frame_q[STOP_POS]
                    & (^frame_q[PARITY_POS:DATA_LSB]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_hist  <= 1'b1;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            state_q   <= ST_IDLE;
            code_q    <= 8'h00;
            ready_q   <= 1'b0;
            count_q   <= 8'h00;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_hist  <= clk_sync[1];
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            state_q   <= state_d;
            ready_q   <= accept;
            if (accept) begin
                code_q  <= frame_q[DATA_MSB:DATA_LSB];
                count_q <= count_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        to_cnt_d  = '0;
        accept    = 1'b0;

        if (state_q == ST_CHECK) begin
            accept  = frame_ok;
            state_d = ST_IDLE;
        end

        // A partial frame whose clock idles high too long is abandoned.
        if (bit_cnt_q != 4'd0 && clk_sync[1]) begin
            if (to_cnt_q == TW'(PS2_TIMEOUT - 1)) begin
                bit_cnt_d = 4'd0;
                state_d   = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        // LSB arrives first, so shift in from the top.
        if (fall) begin
            frame_d = {data_sync[1], frame_q[FRAME_BITS-1:1]};
            if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                bit_cnt_d = 4'd0;
                state_d   = ST_CHECK;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                state_d   = ST_RECV;
            end
        end
    end

    assign kbd.code  = code_q;
    assign kbd.ready = ready_q;
    assign kbd.count = count_q;
    assign kbd.state = state_q;

endmodule

// File: rtl/board_io.sv
// Board I/O top: rotating LED pattern mixed with switches, PS/2 keyboard
// receiver, and hex display of the last scancode and accepted-frame count.
module board_io
    import board_io_pkg::*;
#(
    parameter int LED_DIV     = 5_000_000,
    parameter int PS2_TIMEOUT = 50_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  sw,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] ledr,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7,
    output logic [7:0]  kbd_code,
    output logic        kbd_ready
);

    localparam int CW = $clog2(LED_DIV + 1);

    logic [CW-1:0] led_cnt;
    logic [15:0]   rot;

    board_io_if kbd_bus ();

    ps2_rx #(
        .PS2_TIMEOUT(PS2_TIMEOUT)
    ) u_rx (
        .clk     (clk),
        .resetn  (resetn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .kbd     (kbd_bus.master)
    );

    // Rotation happens in the same cycle the divider wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_cnt <= '0;
            rot     <= 16'h0001;
        end else if (led_cnt == CW'(LED_DIV - 1)) begin
            led_cnt <= '0;
            rot     <= {rot[14:0], rot[15]};
        end else begin
            led_cnt <= led_cnt + 1'b1;
        end
    end

    assign ledr      = {rot[15:8], rot[7:0] ^ sw};
    assign kbd_code  = kbd_bus.code;
    assign kbd_ready = kbd_bus.ready;

    assign seg0 = hex_to_seg(kbd_bus.code[3:0]);
    assign seg1 = hex_to_seg(kbd_bus.code[7:4]);
    assign seg2 = hex_to_seg(kbd_bus.count[3:0]);
    assign seg3 = hex_to_seg(kbd_bus.count[7:4]);
    assign seg4 = SEG_BLANK;
    assign seg5 = SEG_BLANK;
    assign seg6 = SEG_BLANK;
    assign seg7 = SEG_BLANK;

endmodule

// File: tb/tb_board_io.sv
// Directed bench for board_io: LED rotation, PS/2 frames (valid, bad parity,
// timeout, 256-frame wrap) and mid-frame reset.
module tb_board_io;
    import board_io_pkg::*;

    localparam int LED_DIV     = 4;
    localparam int PS2_TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] ledr;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [7:0]  kbd_code;
    logic        kbd_ready;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_pulses = 0;
    logic [7:0]  exp_q[$];

    board_io #(
        .LED_DIV    (LED_DIV),
        .PS2_TIMEOUT(PS2_TIMEOUT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sw       (sw),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ledr     (ledr),
        .seg0     (seg0),
        .seg1     (seg1),
        .seg2     (seg2),
        .seg3     (seg3),
        .seg4     (seg4),
        .seg5     (seg5),
        .seg6     (seg6),
        .seg7     (seg7),
        .kbd_code (kbd_code),
        .kbd_ready(kbd_ready)
    );

    board_io_if mon_if ();
    assign mon_if.code  = kbd_code;
    assign mon_if.ready = kbd_ready;
    assign mon_if.count = dut.kbd_bus.count;
    assign mon_if.state = dut.kbd_bus.state;

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: one PS/2 frame (or its first nbits), clock low 4 / high 4 cycles
    task automatic send_frame(input logic [7:0] data, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            wait_cyc(2);
            ps2_clk = 1'b0;
            wait_cyc(4);
            ps2_clk = 1'b1;
            wait_cyc(4);
        end
        ps2_data = 1'b1;
    endtask

    // scoreboard: every ready cycle must match the next expected scancode
    always @(negedge clk) begin
        if (resetn && kbd_ready === 1'b1) begin
            n_pulses++;
            if (exp_q.size() > 0) check("kbd_code_at_ready", {24'h0, kbd_code}, {24'h0, exp_q.pop_front()});
            else check("ready_without_expected", 32'(exp_q.size()), 32'd1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ledr"},  {16'h0, ledr}, 32'h0001);
        check({tag, "_code"},  {24'h0, kbd_code}, 32'h00);
        check({tag, "_ready"}, {31'h0, kbd_ready}, 32'h0);
        check({tag, "_seg0"},  {24'h0, seg0}, 32'hC0);
        check({tag, "_seg1"},  {24'h0, seg1}, 32'hC0);
        check({tag, "_seg2"},  {24'h0, seg2}, 32'hC0);
        check({tag, "_seg3"},  {24'h0, seg3}, 32'hC0);
        check({tag, "_seg47"}, {seg4, seg5, seg6, seg7}, 32'hFFFF_FFFF);
        check({tag, "_state"}, {30'h0, mon_if.state}, {30'h0, ST_IDLE});
    endtask

    initial begin
        // reset state
        wait_cyc(3);
        sw = 8'hFF;
        #1 check("reset_ledr_sw_ff", {16'h0, ledr}, 32'h00FE);
        sw = 8'h00;
        #1 check_reset_outputs("reset");

        // LED rotation after release
        @(negedge clk);
        resetn = 1'b1;
        sw = 8'hFF;
        #1 check("ledr_sw_ff_rot1", {16'h0, ledr}, 32'h00FE);
        sw = 8'h00;
        #1 check("ledr_t0", {16'h0, ledr}, 32'h0001);
        wait_cyc(4);
        check("ledr_t4", {16'h0, ledr}, 32'h0002);
        wait_cyc(4);
        check("ledr_t8", {16'h0, ledr}, 32'h0004);

        // valid 0x1C
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 11);
        wait_cyc(10);
        check("pulses_1c", 32'(n_pulses), 32'd1);
        check("code_1c", {24'h0, kbd_code}, 32'h1C);
        check("seg0_1c", {24'h0, seg0}, 32'hC6);
        check("seg1_1c", {24'h0, seg1}, 32'hF9);
        check("seg2_1c", {24'h0, seg2}, 32'hF9);
        check("seg3_1c", {24'h0, seg3}, 32'hC0);

        // bad parity is ignored
        send_frame(8'h1C, 1'b1, 11);
        wait_cyc(10);
        check("pulses_badpar", 32'(n_pulses), 32'd1);
        check("code_badpar", {24'h0, kbd_code}, 32'h1C);
        check("seg0_badpar", {24'h0, seg0}, 32'hC6);
        check("seg2_badpar", {24'h0, seg2}, 32'hF9);

        // partial frame then timeout, then valid 0xF0
        send_frame(8'hA5, 1'b0, 6);
        check("state_partial", {30'h0, mon_if.state}, {30'h0, ST_RECV});
        wait_cyc(PS2_TIMEOUT + 50);
        check("state_timeout", {30'h0, mon_if.state}, {30'h0, ST_IDLE});
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 11);
        wait_cyc(10);
        check("pulses_f0", 32'(n_pulses), 32'd2);
        check("code_f0", {24'h0, kbd_code}, 32'hF0);
        check("seg0_f0", {24'h0, seg0}, 32'hC0);
        check("seg1_f0", {24'h0, seg1}, 32'h8E);
        check("seg2_f0", {24'h0, seg2}, 32'hA4);

        // 254 more frames: count wraps to 0x00
        for (int i = 0; i < 254; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b0, 11);
            wait_cyc(10);
        end
        check("pulses_wrap", 32'(n_pulses), 32'd256);
        check("count_wrap", {24'h0, mon_if.count}, 32'h00);
        check("seg2_wrap", {24'h0, seg2}, 32'hC0);
        check("seg3_wrap", {24'h0, seg3}, 32'hC0);
        check("code_wrap", {24'h0, kbd_code}, 32'hFD);
        check("seg0_wrap", {24'h0, seg0}, 32'hA1);
        check("seg1_wrap", {24'h0, seg1}, 32'h8E);

        // reset mid-frame discards the partial frame
        send_frame(8'h33, 1'b0, 5);
        resetn = 1'b0;
        wait_cyc(2);
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        resetn = 1'b1;
        wait_cyc(2);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 11);
        wait_cyc(10);
        check("pulses_after_reset", 32'(n_pulses), 32'd257);
        check("code_5a", {24'h0, kbd_code}, 32'h5A);
        check("seg0_5a", {24'h0, seg0}, 32'h88);
        check("seg1_5a", {24'h0, seg1}, 32'h92);
        check("seg2_5a", {24'h0, seg2}, 32'hF9);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/board_io.md
BOARD_IO -- requirements
Module: board_io

Interface
REQ-001 The module SHALL use one clock and reset exactly as follows: clk is the single clock; resetn is an asynchronous, active-low reset.
REQ-002 Parameter LED_DIV, default 5_000_000: number of clk cycles between LED rotations.
REQ-003 Parameter PS2_TIMEOUT, default 50_000: number of clk cycles of ps2_clk held high that aborts a partial frame.
REQ-004 Port clk, input, 1 bit: system clock.
REQ-005 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port sw, input, 8 bits: switch inputs.
REQ-007 Port ps2_clk, input, 1 bit: asynchronous PS/2 clock.
REQ-008 Port ps2_data, input, 1 bit: asynchronous PS/2 data.
REQ-009 Port ledr, output, 16 bits: LED drive.
REQ-010 Port seg0..seg7, output, 8 bits each: seven-segment digits, active-low; bit0=a .. bit6=g, bit7=dp.
REQ-011 Port kbd_code, output, 8 bits: last valid scancode.
REQ-012 Port kbd_ready, output, 1 bit: one-cycle pulse marking a new valid scancode.

Function
REQ-013 LED rotation:
- A 16-bit register rot SHALL rotate left by one position every LED_DIV clk cycles, using a counter 0..LED_DIV-1.
- The rotation SHALL fire in the cycle the counter wraps.
REQ-014 ledr SHALL equal {rot[15:8], rot[7:0] XOR sw}, combinationally from sw.
REQ-015 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected from the synchronized ps2_clk and one further history flop.
REQ-016 Frame capture:
- On each detected falling edge, the module SHALL sample the synchronized ps2_data into an 11-bit frame, LSB first, and increment a bit counter 0..10.
- Frame layout: start, data[7:0], parity, stop.
REQ-017 In the cycle after the 11th bit is sampled, the frame SHALL be accepted only if start=0, stop=1, and the XOR of data[7:0] and parity is 1 (odd parity).
REQ-018 Accepted frame:
- kbd_code SHALL update to data[7:0] and kbd_ready SHALL be high for exactly that one cycle.
- An 8-bit frame counter SHALL increment, wrapping from 0xFF to 0x00.
REQ-019 Rejected frame: kbd_code, kbd_ready and the counter SHALL remain unchanged; the bit counter SHALL return to 0 in every case.
REQ-020 Timeout: if the bit counter is nonzero and synchronized ps2_clk stays high for PS2_TIMEOUT consecutive cycles, the bit counter SHALL clear and the partial frame SHALL be discarded.
REQ-021 Seven-segment mapping:
- seg0 = hex of kbd_code[3:0]; seg1 = hex of kbd_code[7:4].
- seg2 = hex of frame count[3:0]; seg3 = hex of count[7:4].
- seg4..seg7 = 8'hFF (blank).
REQ-022 Hex encoding, dp always off:
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
- 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-023 Segment outputs SHALL be combinational from registered state.

Reset
REQ-024 While resetn=0:
- rot=16'h0001 and LED counter=0, so ledr = {8'h00, 8'h01 XOR sw}.
- kbd_code=0x00, kbd_ready=0, frame count=0, bit counter=0, timeout counter=0.
- Synchronizers are set to 1.
- seg0..seg3=C0, seg4..seg7=FF.
REQ-025 Reset asserted mid-frame SHALL discard the frame.

Structure
REQ-026 A shared package SHALL hold the 16-entry hex-to-segment constant table, the blank constant 8'hFF, and the frame-field bit positions.
REQ-027 The PS/2 receiver (synchronizers, edge detect, shift register, validation, timeout) SHALL be a sub-module named ps2_rx; LED and segment logic SHALL stay in board_io.

Verification
REQ-028 Reset release with LED_DIV=4, sw=0x00: ledr = 0001, then 0002 after 4 cycles, then 0004 after 8 cycles; with sw=0xFF and rot=0001, ledr=00FE.
REQ-029 Send frame 0,(0x1C LSB first),parity 0,stop 1: one kbd_ready pulse, kbd_code=0x1C, seg0=C6, seg1=F9, seg2=F9, seg3=C0.
REQ-030 Same frame with parity=1: no kbd_ready, kbd_code and segs unchanged.
REQ-031 Send 6 bits, idle beyond PS2_TIMEOUT, then send a valid 0xF0 frame: exactly one pulse, kbd_code=0xF0, seg0=C0, seg1=8E.
REQ-032 Send 256 valid frames: counter wraps, seg2=C0, seg3=C0; also assert resetn low mid-frame and check all outputs return to reset values.
